multicycle_ctrl_fsm: RTL and testbench

// - Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB.
// - Drives the same control encoding as the single-cycle decoder (memtoreg, aluop, alusrc, mux_inp, branch).
// - Adds req/ready handshakes to instruction and data memory, PC/IR write strobes, memory watchdog and trap state.
// - Sits between the IR/PC registers and the shared ALU/regfile/memory datapath.
//

---
 rtl/multicycle_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm - RV32I FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// watchdog and trap; define PERF_CNT_EN for cycle/instret counters. Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       branch,
  output logic       mux_inp,
  output logic       alusrc,
  output logic [1:0] memtoreg,
  output logic [2:0] aluop,
  output logic       reg_write,
  output logic       halted,
  output logic [1:0] err_code
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_BR  = 2'd3;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ILL   = 2'b01;
  localparam logic [1:0] E_IMEM  = 2'b10;
  localparam logic [1:0] E_DMEM  = 2'b11;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [2:0]      boundary;
  logic [1:0]      kind;
  logic [1:0]      err_nxt;
  logic [TO_W-1:0] wd;
  logic            req_wait;

  logic            dec_legal;
  logic [1:0]      dec_kind;
  logic            dec_alusrc;
  logic [2:0]      dec_aluop;
  logic [1:0]      dec_mtr;
  logic            dec_branch;
  logic            dec_jalr;

  // Taken/not-taken is resolved by the next-PC mux; the FSM pulses pc_we either way.
  logic unused_branch_taken;
  assign unused_branch_taken = branch_taken;

  assign boundary = run_en ? S_FETCH : S_IDLE;
  assign halted   = (state == S_TRAP);
  assign req_wait = ((state == S_FETCH) && !imem_ready) ||
                    ((state == S_MEM)   && !dmem_ready);

  always_comb begin
    dec_legal  = 1'b1;
    dec_kind   = K_ALU;
    dec_alusrc = 1'b1;
    dec_aluop  = 3'b000;
    dec_mtr    = 2'b00;
    dec_branch = 1'b0;
    dec_jalr   = 1'b0;
    case (opcode)
      7'b0110011: dec_alusrc = 1'b0;
      7'b0010011: dec_aluop  = 3'b001;
      7'b0000011: begin
        dec_kind  = K_LD;
        dec_aluop = 3'b010;
        dec_mtr   = 2'b01;
      end
      7'b0100011: begin
        dec_kind  = K_ST;
        dec_aluop = 3'b011;
        dec_mtr   = 2'b11;
      end
      7'b1100011: begin
        dec_kind   = K_BR;
        dec_alusrc = 1'b0;
        dec_aluop  = 3'b100;
        dec_branch = 1'b1;
      end
      7'b1101111: begin
        dec_aluop = 3'b101;
        dec_mtr   = 2'b10;
      end
      7'b1100111: begin
        dec_aluop = 3'b001;
        dec_mtr   = 2'b10;
        dec_jalr  = 1'b1;
      end
      7'b0110111: begin
        dec_aluop = 3'b110;
        dec_mtr   = 2'b10;
      end
      7'b0010111: dec_mtr = 2'b10;
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wd == WD_LAST) begin
          state_nxt = S_TRAP;
          err_nxt   = E_IMEM;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          err_nxt   = E_ILL;
        end
      end
      S_EXEC: begin
        case (kind)
          K_LD, K_ST: state_nxt = S_MEM;
          K_BR: begin
            pc_we     = 1'b1;
            state_nxt = boundary;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (kind == K_ST);
        if (dmem_ready) begin
          if (kind == K_ST) begin
            pc_we     = 1'b1;
            state_nxt = boundary;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wd == WD_LAST) begin
          state_nxt = S_TRAP;
          err_nxt   = E_DMEM;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        state_nxt = boundary;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Watchdog only advances while the FSM sits in a waiting state; any move clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      err_code <= E_NONE;
      wd       <= '0;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
      wd       <= (req_wait && (state_nxt == state)) ? wd + TO_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind     <= K_ALU;
      alusrc   <= 1'b0;
      aluop    <= 3'b000;
      memtoreg <= 2'b11;
      branch   <= 1'b0;
      mux_inp  <= 1'b0;
    end else if ((state == S_DECODE) && dec_legal) begin
      kind     <= dec_kind;
      alusrc   <= dec_alusrc;
      aluop    <= dec_aluop;
      memtoreg <= dec_mtr;
      branch   <= dec_branch;
      mux_inp  <= dec_jalr;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instret   <= 32'd0;
    end else begin
      if ((state != S_IDLE) && (state != S_TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret <= instret + 32'd1;
    end
  end
`endif

  a_trap_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> !(imem_req || dmem_req || ir_we || pc_we || reg_write));
  a_we_qual: assert property (@(posedge clk) disable iff (!rst_n)
    dmem_we |-> dmem_req);
  a_wb_pc: assert property (@(posedge clk) disable iff (!rst_n)
    reg_write |-> pc_we);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm - randomized instruction stream against a trace model
// of the sequencer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;

  localparam logic [6:0] S_IREQ = 7'b1000000;
  localparam logic [6:0] S_IRWE = 7'b0100000;
  localparam logic [6:0] S_DREQ = 7'b0010000;
  localparam logic [6:0] S_DWE  = 7'b0001000;
  localparam logic [6:0] S_PCWE = 7'b0000100;
  localparam logic [6:0] S_RWR  = 7'b0000010;
  localparam logic [6:0] S_HALT = 7'b0000001;

  localparam logic [7:0] CTL_RST = 8'b0_000_11_0_0;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_BR  = 3;
  localparam int K_ILL = 4;

  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run_en, branch_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, branch, mux_inp, alusrc;
  logic [1:0] memtoreg;
  logic [2:0] aluop;
  logic       reg_write, halted;
  logic [1:0] err_code;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .branch(branch), .mux_inp(mux_inp), .alusrc(alusrc),
    .memtoreg(memtoreg), .aluop(aluop), .reg_write(reg_write), .halted(halted),
    .err_code(err_code)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  logic [8:0] obs_s;
  logic [7:0] obs_ctl;
  assign obs_s   = {imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_write, halted, err_code};
  assign obs_ctl = {alusrc, aluop, memtoreg, branch, mux_inp};

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_ctl;
  logic [1:0]  exp_err;
  bit          ctl_known;
  logic [31:0] exp_cyc;
  logic [31:0] exp_ret;
  bit          bt_fixed;
  logic        bt_val;
  logic [6:0]  legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic int ref_kind(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return K_ALU;
      default: return K_ILL;
    endcase
  endfunction

  // {alusrc, aluop, memtoreg, branch, mux_inp}
  function automatic logic [7:0] ref_ctl(input logic [6:0] op);
    case (op)
      7'b0110011: return 8'b0_000_00_0_0;
      7'b0010011: return 8'b1_001_00_0_0;
      7'b0000011: return 8'b1_010_01_0_0;
      7'b0100011: return 8'b1_011_11_0_0;
      7'b1100011: return 8'b0_100_00_1_0;
      7'b1101111: return 8'b1_101_10_0_0;
      7'b1100111: return 8'b1_001_10_0_1;
      7'b0110111: return 8'b1_110_10_0_0;
      7'b0010111: return 8'b1_000_10_0_0;
      default:    return 8'h00;
    endcase
  endfunction

  // One clock: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic cyc(input logic [6:0] exp_s, input logic imr, input logic dmr,
                     input logic run, input logic [6:0] op, input bit act, input string tag);
    imem_ready   = imr;
    dmem_ready   = dmr;
    run_en       = run;
    opcode       = op;
    branch_taken = bt_fixed ? bt_val : rb();
    @(negedge clk);
    check_val({tag, " strobes"}, 32'(obs_s), 32'({exp_s, exp_err}));
    if (ctl_known) check_val({tag, " ctl"}, 32'(obs_ctl), 32'(exp_ctl));
`ifdef PERF_CNT_EN
    check_val({tag, " cycle_cnt"}, cycle_cnt, exp_cyc);
    check_val({tag, " instret"}, instret, exp_ret);
`endif
    if (act) exp_cyc = exp_cyc + 32'd1;
    if ((exp_s & S_PCWE) != 7'd0) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(7'd0, rb(), rb(), (k == n - 1), rop(), 1'b0, "idle");
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) cyc(S_HALT, rb(), rb(), rb(), rop(), 1'b0, "trap");
  endtask

  task automatic reset_tail();
    exp_ctl   = CTL_RST;
    exp_err   = 2'b00;
    ctl_known = 1'b1;
    exp_cyc   = 32'd0;
    exp_ret   = 32'd0;
    cyc(7'd0, rb(), rb(), rb(), rop(), 1'b0, "reset");
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    reset_tail();
  endtask

  // di/dd: ready-low cycles before imem/dmem ready; >= TO means the memory never answers.
  task automatic run_instr(input logic [6:0] op, input int di, input int dd,
                           input bit next_run, input bit abort_mem);
    int         kd;
    bit         st;
    bit         last;
    logic [6:0] s;
    kd = ref_kind(op);
    st = (kd == K_ST);
    for (int k = 0; k <= di; k++) begin
      last = (k == di);
      cyc(last ? (S_IREQ | S_IRWE) : S_IREQ, last, rb(), rb(), rop(), 1'b1, "fetch");
      if (!last && k == TO - 1) begin
        exp_err   = 2'b10;
        ctl_known = 1'b0;
        trap_hold(4);
        return;
      end
    end
    cyc(7'd0, rb(), rb(), rb(), op, 1'b1, "decode");
    if (kd == K_ILL) begin
      exp_err   = 2'b01;
      ctl_known = 1'b0;
      trap_hold(4);
      return;
    end
    exp_ctl = ref_ctl(op);
    if (kd == K_BR) begin
      cyc(S_PCWE, rb(), rb(), next_run, rop(), 1'b1, "exec_br");
      return;
    end
    cyc(7'd0, rb(), rb(), rb(), rop(), 1'b1, "exec");
    if (kd == K_LD || kd == K_ST) begin
      for (int k = 0; k <= dd; k++) begin
        last = (k == dd);
        s = S_DREQ | (st ? S_DWE : 7'd0) | ((last && st) ? S_PCWE : 7'd0);
        if (abort_mem) begin
          rst_n = 1'b0;
          cyc(s, rb(), 1'b0, rb(), rop(), 1'b1, "mem_abort");
          reset_tail();
          return;
        end
        cyc(s, rb(), last, (last && st) ? next_run : rb(), rop(), 1'b1, "mem");
        if (!last && k == TO - 1) begin
          exp_err   = 2'b11;
          ctl_known = 1'b0;
          trap_hold(4);
          return;
        end
        if (last && st) return;
      end
    end
    cyc(S_RWR | S_PCWE, rb(), rb(), next_run, rop(), 1'b1, "wb");
  endtask

  initial begin
    bit nr;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    run_en       = 1'b0;
    opcode       = 7'd0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    bt_fixed     = 1'b0;
    bt_val       = 1'b0;
    exp_ctl      = CTL_RST;
    exp_err      = 2'b00;
    ctl_known    = 1'b1;
    exp_cyc      = 32'd0;
    exp_ret      = 32'd0;
    @(posedge clk);
    #1;
    reset_tail();
    idle(2);

    run_instr(OP_ADD, 0, 0, 1'b1, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b1, 1'b0);
    bt_fixed = 1'b1;
    bt_val   = 1'b1;
    run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    bt_val   = 1'b0;
    run_instr(OP_BEQ, 0, 0, 1'b0, 1'b0);
    bt_fixed = 1'b0;
    idle(3);

    for (int i = 0; i < 120; i++) begin
      nr = ($urandom_range(0, 7) != 0);
      run_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), nr, 1'b0);
      if (!nr) idle(int'($urandom_range(1, 3)));
    end

    run_instr(OP_SW, 1, 2, 1'b1, 1'b1);
    idle(1);

    run_instr(OP_ADD, 0, 0, 1'b1, 1'b0);
    run_instr(OP_ADD, 0, 0, 1'b1, 1'b0);
    run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
`ifdef PERF_CNT_EN
    check_val("instret_3_adds", instret, 32'd3);
`endif
    idle(1);

    run_instr(OP_LW, 0, 10, 1'b1, 1'b0);
    do_reset();
    idle(1);
    run_instr(OP_ADD, 10, 0, 1'b1, 1'b0);
    do_reset();
    idle(1);
    run_instr(7'b1111111, 0, 0, 1'b1, 1'b0);
    trap_hold(3);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
